// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: hazard/ID-stage control into the PC unit, IM address and IF/ID registers out.
// The slave modport is the fetch unit; the master modport is the surrounding pipeline (or bench).
interface fetch_pc_unit_if;
  logic        stall;
  logic [31:0] instr_if;
  logic [31:0] pc_if;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [31:0] imm32_id;
  logic [31:0] jr_target;
  logic [31:0] instr_id;
  logic [31:0] pc_id;
  logic [31:0] pc8_id;
  logic        fetch_err;

  modport master (
    output stall, instr_if, npc_sel, br_taken, imm32_id, jr_target,
    input  pc_if, instr_id, pc_id, pc8_id, fetch_err
  );

  modport slave (
    input  stall, instr_if, npc_sel, br_taken, imm32_id, jr_target,
    output pc_if, instr_id, pc_id, pc8_id, fetch_err
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// MIPS IF stage: PC register, next-PC select from ID-stage redirects, IF/ID register; delay slot kept.
// Optional macro FETCH_ALIGN_CHECK_EN adds a sticky misaligned-target flag on fetch_err.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic           clk,
  input logic           reset,
  fetch_pc_unit_if.slave bus
);
  localparam logic [1:0] SEL_SEQ = 2'b00, SEL_BR = 2'b01, SEL_J = 2'b10, SEL_JR = 2'b11;

  logic [31:0] pc, pc_d, instr_d, pc8_d;
  logic [31:0] npc, seq_pc, br_pc, j_pc;

  // Redirect targets are formed from the instruction in ID, not the one being fetched.
  assign seq_pc = pc + 32'd4;
  assign br_pc  = pc_d + 32'd4 + {bus.imm32_id[29:0], 2'b00};
  assign j_pc   = {pc_d[31:28], instr_d[25:0], 2'b00};

  always_comb begin
    npc = seq_pc;
    case (bus.npc_sel)
      SEL_SEQ: npc = seq_pc;
      SEL_BR:  npc = bus.br_taken ? br_pc : seq_pc;
      SEL_J:   npc = j_pc;
      SEL_JR:  npc = bus.jr_target;
      default: npc = seq_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      instr_d <= 32'd0;
      pc_d    <= 32'd0;
      pc8_d   <= 32'd8;
    end else if (!bus.stall) begin
      pc      <= npc;
      instr_d <= bus.instr_if;
      pc_d    <= pc;
      pc8_d   <= pc + 32'd8;
    end
  end

  assign bus.pc_if    = pc;
  assign bus.instr_id = instr_d;
  assign bus.pc_id    = pc_d;
  assign bus.pc8_id   = pc8_d;

`ifdef FETCH_ALIGN_CHECK_EN
  logic err;
  // Only jr/jalr can produce a misaligned target; the PC still takes the raw value.
  always_ff @(posedge clk) begin
    if (reset)
      err <= 1'b0;
    else if (!bus.stall && (npc[1:0] != 2'b00))
      err <= 1'b1;
  end
  assign bus.fetch_err = err;
`else
  assign bus.fetch_err = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: per-scenario stimulus with a queue of expected register states.
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic reset;
  fetch_pc_unit_if bus ();

  fetch_pc_unit #(.RESET_PC(32'h0000_3000)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic ALIGN = 1'b1;
`else
  localparam logic ALIGN = 1'b0;
`endif

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic [1:0]  sel;
    logic        br;
    logic [31:0] imm;
    logic [31:0] jr;
    logic [31:0] instr;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc_if;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic [31:0] pc8_id;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  task automatic apply(input stim_t s);
    reset        = s.rst;
    bus.stall    = s.stall;
    bus.npc_sel  = s.sel;
    bus.br_taken = s.br;
    bus.imm32_id = s.imm;
    bus.jr_target = s.jr;
    bus.instr_if = s.instr;
  endtask

  function automatic stim_t st(logic rst, logic stall, logic [1:0] sel, logic br,
                               logic [31:0] imm, logic [31:0] jr, logic [31:0] instr);
    return '{rst, stall, sel, br, imm, jr, instr};
  endfunction

  function automatic exp_t ex(logic [31:0] p, logic [31:0] pd, logic [31:0] id,
                              logic [31:0] p8, logic e);
    return '{p, pd, id, p8, e};
  endfunction

  task automatic test_reset();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(1, 0, 2'b00, 0, 0, 0, 32'hDEAD_BEEF)); e.push_back(ex(32'h3000, 0, 0, 8, 0));
    s.push_back(st(1, 1, 2'b11, 0, 0, 32'h1234, 0));      e.push_back(ex(32'h3000, 0, 0, 8, 0));
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = '{bus.pc_if, bus.pc_id, bus.instr_id, bus.pc8_id, bus.fetch_err};
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset[%0d]: got pc_if=%h pc_id=%h instr_id=%h pc8_id=%h err=%b, want pc_if=%h pc_id=%h instr_id=%h pc8_id=%h err=%b",
                 i, got.pc_if, got.pc_id, got.instr_id, got.pc8_id, got.err,
                 want.pc_if, want.pc_id, want.instr_id, want.pc8_id, want.err);
      end
    end
  endtask

  task automatic test_sequential();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(0, 0, 2'b00, 0, 0, 0, 0)); e.push_back(ex(32'h3004, 32'h3000, 0, 32'h3008, 0));
    s.push_back(st(0, 0, 2'b00, 0, 0, 0, 0)); e.push_back(ex(32'h3008, 32'h3004, 0, 32'h300C, 0));
    s.push_back(st(0, 0, 2'b00, 0, 0, 0, 0)); e.push_back(ex(32'h300C, 32'h3008, 0, 32'h3010, 0));
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = '{bus.pc_if, bus.pc_id, bus.instr_id, bus.pc8_id, bus.fetch_err};
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL seq[%0d]: got pc_if=%h pc_id=%h instr_id=%h pc8_id=%h err=%b, want pc_if=%h pc_id=%h instr_id=%h pc8_id=%h err=%b",
                 i, got.pc_if, got.pc_id, got.instr_id, got.pc8_id, got.err,
                 want.pc_if, want.pc_id, want.instr_id, want.pc8_id, want.err);
      end
    end
  endtask

  // beq at 3008 taken backwards, then not-taken branch, then j to 3040 with its delay slot.
  task automatic test_branch_jump();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(0, 0, 2'b01, 1, 32'hFFFF_FFFE, 0, 32'h1111_0000));
    e.push_back(ex(32'h3004, 32'h300C, 32'h1111_0000, 32'h3014, 0));
    s.push_back(st(0, 0, 2'b00, 0, 0, 0, 0));
    e.push_back(ex(32'h3008, 32'h3004, 0, 32'h300C, 0));
    s.push_back(st(0, 0, 2'b01, 0, 32'h0000_0010, 0, 0));
    e.push_back(ex(32'h300C, 32'h3008, 0, 32'h3010, 0));
    s.push_back(st(0, 0, 2'b00, 0, 0, 0, 0));
    e.push_back(ex(32'h3010, 32'h300C, 0, 32'h3014, 0));
    s.push_back(st(0, 0, 2'b00, 0, 0, 0, 32'h0800_0C10));
    e.push_back(ex(32'h3014, 32'h3010, 32'h0800_0C10, 32'h3018, 0));
    s.push_back(st(0, 0, 2'b10, 0, 0, 0, 32'h2222_0000));
    e.push_back(ex(32'h3040, 32'h3014, 32'h2222_0000, 32'h301C, 0));
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = '{bus.pc_if, bus.pc_id, bus.instr_id, bus.pc8_id, bus.fetch_err};
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL brj[%0d]: got pc_if=%h pc_id=%h instr_id=%h pc8_id=%h err=%b, want pc_if=%h pc_id=%h instr_id=%h pc8_id=%h err=%b",
                 i, got.pc_if, got.pc_id, got.instr_id, got.pc8_id, got.err,
                 want.pc_if, want.pc_id, want.instr_id, want.pc8_id, want.err);
      end
    end
  endtask

  // jr held in ID for two stalled cycles, then applied exactly once.
  task automatic test_stall_jr();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(0, 0, 2'b00, 0, 0, 0, 32'h03E0_0008));
    e.push_back(ex(32'h3044, 32'h3040, 32'h03E0_0008, 32'h3048, 0));
    s.push_back(st(0, 1, 2'b11, 0, 0, 32'h3100, 32'h3333_0000));
    e.push_back(ex(32'h3044, 32'h3040, 32'h03E0_0008, 32'h3048, 0));
    s.push_back(st(0, 1, 2'b11, 0, 0, 32'h3100, 32'h3333_0000));
    e.push_back(ex(32'h3044, 32'h3040, 32'h03E0_0008, 32'h3048, 0));
    s.push_back(st(0, 0, 2'b11, 0, 0, 32'h3100, 32'h3333_0000));
    e.push_back(ex(32'h3100, 32'h3044, 32'h3333_0000, 32'h304C, 0));
    s.push_back(st(0, 0, 2'b00, 0, 0, 32'h3100, 0));
    e.push_back(ex(32'h3104, 32'h3100, 0, 32'h3108, 0));
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = '{bus.pc_if, bus.pc_id, bus.instr_id, bus.pc8_id, bus.fetch_err};
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL stall_jr[%0d]: got pc_if=%h pc_id=%h instr_id=%h pc8_id=%h err=%b, want pc_if=%h pc_id=%h instr_id=%h pc8_id=%h err=%b",
                 i, got.pc_if, got.pc_id, got.instr_id, got.pc8_id, got.err,
                 want.pc_if, want.pc_id, want.instr_id, want.pc8_id, want.err);
      end
    end
  endtask

  // Misaligned jr: stalled cycle must not flag, loaded cycle does, flag sticks until reset.
  task automatic test_align();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(0, 1, 2'b11, 0, 0, 32'h3102, 0));
    e.push_back(ex(32'h3104, 32'h3100, 0, 32'h3108, 0));
    s.push_back(st(0, 0, 2'b11, 0, 0, 32'h3102, 0));
    e.push_back(ex(32'h3102, 32'h3104, 0, 32'h310C, ALIGN));
    s.push_back(st(0, 0, 2'b00, 0, 0, 0, 0));
    e.push_back(ex(32'h3106, 32'h3102, 0, 32'h310A, ALIGN));
    s.push_back(st(1, 1, 2'b11, 0, 0, 32'h3200, 0));
    e.push_back(ex(32'h3000, 0, 0, 8, 0));
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = '{bus.pc_if, bus.pc_id, bus.instr_id, bus.pc8_id, bus.fetch_err};
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL align[%0d]: got pc_if=%h pc_id=%h instr_id=%h pc8_id=%h err=%b, want pc_if=%h pc_id=%h instr_id=%h pc8_id=%h err=%b",
                 i, got.pc_if, got.pc_id, got.instr_id, got.pc8_id, got.err,
                 want.pc_if, want.pc_id, want.instr_id, want.pc8_id, want.err);
      end
    end
  endtask

  // PC and link address wrap mod 2^32; branch offset drops imm bits 31:30.
  task automatic test_wrap();
    stim_t s[$];
    exp_t  e[$];
    exp_t  got, want;
    s.push_back(st(0, 0, 2'b11, 0, 0, 32'hFFFF_FFFC, 0));
    e.push_back(ex(32'hFFFF_FFFC, 32'h3000, 0, 32'h3008, 0));
    s.push_back(st(0, 0, 2'b00, 0, 0, 0, 32'h4444_0000));
    e.push_back(ex(32'h0000_0000, 32'hFFFF_FFFC, 32'h4444_0000, 32'h0000_0004, 0));
    s.push_back(st(0, 0, 2'b01, 1, 32'h4000_0001, 0, 0));
    e.push_back(ex(32'h0000_0004, 32'h0000_0000, 0, 32'h0000_0008, 0));
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back(e[i]);
      @(posedge clk); #1;
      got  = '{bus.pc_if, bus.pc_id, bus.instr_id, bus.pc8_id, bus.fetch_err};
      want = sb.pop_front();
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL wrap[%0d]: got pc_if=%h pc_id=%h instr_id=%h pc8_id=%h err=%b, want pc_if=%h pc_id=%h instr_id=%h pc8_id=%h err=%b",
                 i, got.pc_if, got.pc_id, got.instr_id, got.pc8_id, got.err,
                 want.pc_if, want.pc_id, want.instr_id, want.pc8_id, want.err);
      end
    end
  endtask

  initial begin
    apply(st(1, 0, 2'b00, 0, 0, 0, 0));
    @(negedge clk);
    test_reset();
    test_sequential();
    test_branch_jump();
    test_stall_jr();
    test_align();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage of the five-stage pipelined MIPS core: holds the program counter, computes the next PC, and owns the IF/ID pipeline register. It consumes the sign-extended immediate that the ID-stage immediate extender produces and uses it to form branch targets. Branch and jump resolution happens in ID, and the architectural delay slot is honoured, so no flush path exists.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  from the hazard unit; freezes the PC and IF/ID registers.
- `instr_if`  in  32  instruction word read from IM at `pc_if` (combinational IM).
- `pc_if`  out  32  current fetch address, registered.
- `npc_sel`  in  2  ID-stage control: 00 = sequential, 01 = branch, 10 = j/jal, 11 = jr/jalr.
- `br_taken`  in  1  ID-stage comparator result; used only when `npc_sel`=01.
- `imm32_id`  in  32  sign-extended imm16 of the instruction in ID.
- `jr_target`  in  32  forwarded rs value for jr/jalr.
- `instr_id`  out  32  IF/ID instruction register.
- `pc_id`  out  32  IF/ID PC register.
- `pc8_id`  out  32  IF/ID link-address register (`pc_id`+8).
- `fetch_err`  out  1  sticky misaligned-target flag (see Configuration).

## Operation
- All redirect decisions refer to the instruction in ID (`instr_id`, `pc_id`), never the one in IF.
- Next PC, evaluated every cycle:
  - `npc_sel`=01 and `br_taken`=1: `pc_id` + 4 + (`imm32_id` << 2).
  - `npc_sel`=01 and `br_taken`=0: `pc_if` + 4.
  - `npc_sel`=10: {`pc_id`[31:28], `instr_id`[25:0], 2'b00}.
  - `npc_sel`=11: `jr_target`, unmodified.
  - `npc_sel`=00: `pc_if` + 4.
- All arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. The shifted immediate drops bits 31:30 of `imm32_id`.
- Delay slot: when a redirect is in ID, the instruction in IF is the delay slot. It is latched into IF/ID normally and never squashed.
- IF/ID update when not stalled: `instr_id` <= `instr_if`, `pc_id` <= `pc_if`, `pc8_id` <= `pc_if` + 8.
- `stall`=1: PC and all IF/ID registers hold. The held ID instruction re-presents the same redirect on the next unstalled cycle, so the redirect is applied exactly once.
- Reset has priority over stall.

## Timing
- Reset values: `pc_if`=`RESET_PC`, `instr_id`=0 (nop), `pc_id`=0, `pc8_id`=32'h8, `fetch_err`=0.
- The first fetch is from `RESET_PC` in the cycle after reset deasserts.
- Redirect latency: a branch or jump entering ID in cycle N makes `pc_if` equal the target in cycle N+1. The delay slot occupies ID in cycle N+1.
- `pc_if` to IM is a direct register output; next-PC logic is combinational from ID-stage inputs into the PC register.
- Reset asserted mid-stall or mid-redirect: all state returns to its reset values on the next edge and the pending redirect is discarded.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - On any unstalled cycle that loads a next-PC value with bits [1:0] ≠ 0 (jr/jalr is the only source), `fetch_err` sets and stays at 1 until reset.
  - The PC is still loaded with the full, unaligned value.
- Not defined: `fetch_err` is constant 0 and no check logic is synthesised.

## Test plan
- Reset then 3 free-running cycles, IM returning 32'h0000_0000 -> `pc_if` = 3000, 3004, 3008, 300C; `pc_id` one cycle behind; `pc8_id` = `pc_id`+8.
- beq at 3008 taken, `imm32_id`=32'hFFFF_FFFE -> delay slot at 300C enters ID, then `pc_if`=3004 (3008+4−8).
- j with `instr_id`[25:0]=26'h0000C10 at `pc_id`=3010 -> next `pc_if`=32'h0000_3040; the delay slot at 3014 still reaches ID.
- jr held in ID with `stall`=1 for 2 cycles, `jr_target`=32'h0000_3100 -> `pc_if` and IF/ID frozen both cycles; `pc_if`=3100 one cycle after the stall drops, applied once.
- With `FETCH_ALIGN_CHECK_EN`, jr with `jr_target`=32'h0000_3102 -> `pc_if`=3102 and `fetch_err`=1, held until reset. Without the macro, the same stimulus leaves `fetch_err`=0.
- `pc_if`=32'hFFFF_FFFC with sequential fetch -> next `pc_if`=0.
